brick_redraw_seq: RTL and testbench
===================================

Name: brick_redraw_seq

Overview:
- Sits between the collision logic and the brick drawer in the per-frame draw sequence.
- On a `go` pulse from the main draw FSM, it latches up to two brick-collision records (x, y, new health).
- It then issues one `go_draw` pulse per collided brick, in order, and holds coordinates and health stable for the full draw window.
- It signals `done` when finished, so the main FSM needs no worst-case fixed delay.

Parameters:
- COORD_W, 10, width of the brick x/y coordinates.
- HEALTH_W, 2, width of the health field; 0 means destroyed (drawer paints black).
- DRAW_CYCLES, 40, clocks held after each `go_draw`; must cover one full brick draw.

Ports:
- clk  in  1  system clock (50 MHz).
- resetn  in  1  synchronous, active-low reset.
- go  in  1  single-cycle start pulse from the main draw FSM.
- collided_1  in  1  record 1 valid.
- col_x1  in  COORD_W  record 1 brick x.
- col_y1  in  COORD_W  record 1 brick y.
- col_health1  in  HEALTH_W  record 1 post-hit health.
- collided_2  in  1  record 2 valid.
- col_x2  in  COORD_W  record 2 brick x.
- col_y2  in  COORD_W  record 2 brick y.
- col_health2  in  HEALTH_W  record 2 post-hit health.
- brickx  out  COORD_W  brick x to the drawer.
- bricky  out  COORD_W  brick y to the drawer.
- brickhealth  out  HEALTH_W  health to the drawer.
- go_draw  out  1  single-cycle drawer start pulse.
- busy  out  1  high from the cycle after `go` is accepted until `done`.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset: synchronous, active-low `resetn`, sampled on the `clk` rising edge.
  - All outputs go to 0, the state goes to IDLE, and all latches clear.
  - Reset mid-operation aborts at once; no further `go_draw` or `done` is issued.
- States: IDLE, LATCH, ISSUE1, WAIT1, ISSUE2, WAIT2, FIN.
- IDLE: on `go`=1, capture all six record fields plus both valid bits, then go to LATCH. `go` is ignored in every other state.
- LATCH:
  - If latched valid1, go to ISSUE1.
  - Else if valid2, go to ISSUE2.
  - Else go to FIN.
- ISSUE1:
  - Drive `brickx`/`bricky`/`brickhealth` from record 1 and pulse `go_draw`=1 for one cycle.
  - Load the wait counter with DRAW_CYCLES-1, then go to WAIT1.
- WAIT1:
  - Hold the outputs; the counter decrements each clock.
  - At 0: go to ISSUE2 if valid2 (and it is not suppressed, see Optional Feature), else go to FIN.
- ISSUE2 / WAIT2: same as ISSUE1 / WAIT1 using record 2; WAIT2 exits to FIN.
- FIN: pulse `done` for one cycle, then return to IDLE.
- `brickx`/`bricky`/`brickhealth` keep their last driven values in IDLE; they change only in ISSUE states.
- Latency from `go` to `done`:
  - Both records: 3 + 2·(DRAW_CYCLES+1) clocks = 85 at default.
  - One record: 44 clocks.
  - No records: 3 clocks.
- `busy` = (state ≠ IDLE).
- Inputs change freely after `go`; only the latched copies are used.
- Health is passed through unmodified, including 0.

Optional Feature:
- Macro BRICK_REDRAW_DEDUP_EN.
- Defined: if both records are valid with equal x and y, record 1 is skipped. LATCH goes directly to ISSUE2, so only record 2 (the later health) is drawn, with one `go_draw`.
- Undefined: both records are drawn in order regardless of equality.

Decomposition:
- Shared package holds:
  - COORD_W and HEALTH_W defaults.
  - The health encoding constants HEALTH_DEAD=0 through HEALTH_FULL=3.
  - The state encoding localparams.
  - The frame-budget constant that the main FSM uses as its brick-draw delay, which must be ≥ the worst-case latency.
- One natural sub-module: `draw_wait_timer` (load, decrement, zero flag, width from DRAW_CYCLES).

Test Plan:
- No collisions: `go` with collided_1=collided_2=0 → no `go_draw`; `done` 3 cycles after `go`; `busy` high for exactly 2 cycles.
- Record 1 only (x=24, y=10, h=1) → one `go_draw` with brickx=24, bricky=10, brickhealth=1 held 41 cycles; `done` at cycle 44.
- Both records ((8,4,0) and (40,16,2)) → `go_draw` pulses 41 cycles apart with the matching values; `done` at cycle 85.
- Same coordinates (16,8,2) and (16,8,1), macro defined → single `go_draw` with health 1. Macro undefined → two pulses, health 2 then 1.
- Second `go` during WAIT1 plus input changes after capture → ignored; outputs reflect only the first latched data.
- `resetn`=0 during WAIT2 → next cycle all outputs 0 and state IDLE; no `done`. A subsequent `go` runs normally.

Source files
------------

// File: rtl/brick_redraw_seq_pkg.sv
// Shared constants for the brick redraw sequencer: field widths,
// health encoding, state encoding and the main-FSM frame budget.
package brick_redraw_seq_pkg;

    localparam int COORD_W_DEF     = 10;
    localparam int HEALTH_W_DEF    = 2;
    localparam int DRAW_CYCLES_DEF = 40;

    localparam logic [1:0] HEALTH_DEAD = 2'd0;
    localparam logic [1:0] HEALTH_LOW  = 2'd1;
    localparam logic [1:0] HEALTH_MID  = 2'd2;
    localparam logic [1:0] HEALTH_FULL = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LATCH  = 3'd1;
    localparam logic [2:0] ST_ISSUE1 = 3'd2;
    localparam logic [2:0] ST_WAIT1  = 3'd3;
    localparam logic [2:0] ST_ISSUE2 = 3'd4;
    localparam logic [2:0] ST_WAIT2  = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LATCH  = ST_LATCH,
        ISSUE1 = ST_ISSUE1,
        WAIT1  = ST_WAIT1,
        ISSUE2 = ST_ISSUE2,
        WAIT2  = ST_WAIT2,
        FIN    = ST_FIN
    } state_e;

    // go-to-done clocks for n drawn bricks
    function automatic int seq_latency(input int n, input int dc);
        return 3 + n * (dc + 1);
    endfunction

    function automatic int timer_w(input int dc);
        return (dc > 2) ? $clog2(dc) : 1;
    endfunction

    localparam int BRICK_DRAW_BUDGET = seq_latency(2, DRAW_CYCLES_DEF) + 3;

endpackage

// File: rtl/brick_redraw_seq_draw_wait_timer.sv
// Down-counter that holds the drawer inputs stable for one brick draw.
// Loads DRAW_CYCLES-1, decrements on request, flags zero.
module draw_wait_timer
    import brick_redraw_seq_pkg::*;
#(
    parameter int DRAW_CYCLES = DRAW_CYCLES_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int W = timer_w(DRAW_CYCLES);
    localparam logic [W-1:0] LOAD_V = W'(DRAW_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = LOAD_V;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/brick_redraw_seq.sv
// Latches up to two brick-collision records and replays them to the drawer.
// Build option: BRICK_REDRAW_DEDUP_EN draws only record 2 when both hit the same brick.
module brick_redraw_seq
    import brick_redraw_seq_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEF,
    parameter int HEALTH_W    = HEALTH_W_DEF,
    parameter int DRAW_CYCLES = DRAW_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                go,
    input  logic                collided_1,
    input  logic [COORD_W-1:0]  col_x1,
    input  logic [COORD_W-1:0]  col_y1,
    input  logic [HEALTH_W-1:0] col_health1,
    input  logic                collided_2,
    input  logic [COORD_W-1:0]  col_x2,
    input  logic [COORD_W-1:0]  col_y2,
    input  logic [HEALTH_W-1:0] col_health2,
    output logic [COORD_W-1:0]  brickx,
    output logic [COORD_W-1:0]  bricky,
    output logic [HEALTH_W-1:0] brickhealth,
    output logic                go_draw,
    output logic                busy,
    output logic                done
);

    state_e state_q;

    logic                v1_q, v2_q;
    logic [COORD_W-1:0]  x1_q, y1_q, x2_q, y2_q;
    logic [HEALTH_W-1:0] h1_q, h2_q;

    logic [COORD_W-1:0]  bx_q, by_q;
    logic [HEALTH_W-1:0] bh_q;
    logic                go_draw_q;
    logic                done_q;

    logic skip1;
    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;

`ifdef BRICK_REDRAW_DEDUP_EN
    assign skip1 = v1_q && v2_q && (x1_q == x2_q) && (y1_q == y2_q);
`else
    assign skip1 = 1'b0;
`endif

    assign tmr_load = (state_q == ISSUE1) || (state_q == ISSUE2);
    assign tmr_dec  = (state_q == WAIT1) || (state_q == WAIT2);

    draw_wait_timer #(
        .DRAW_CYCLES (DRAW_CYCLES)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .load_i (tmr_load),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    // Drawer inputs and go_draw are set on entry to ISSUE so the drawer
    // sees coordinates in the same cycle as its start pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            x1_q      <= '0;
            y1_q      <= '0;
            h1_q      <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
            h2_q      <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            bh_q      <= '0;
            go_draw_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            go_draw_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        v1_q    <= collided_1;
                        x1_q    <= col_x1;
                        y1_q    <= col_y1;
                        h1_q    <= col_health1;
                        v2_q    <= collided_2;
                        x2_q    <= col_x2;
                        y2_q    <= col_y2;
                        h2_q    <= col_health2;
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    if (v1_q && !skip1) begin
                        bx_q      <= x1_q;
                        by_q      <= y1_q;
                        bh_q      <= h1_q;
                        go_draw_q <= 1'b1;
                        state_q   <= ISSUE1;
                    end else if (v2_q) begin
                        bx_q      <= x2_q;
                        by_q      <= y2_q;
                        bh_q      <= h2_q;
                        go_draw_q <= 1'b1;
                        state_q   <= ISSUE2;
                    end else begin
                        state_q <= FIN;
                    end
                end
                ISSUE1: state_q <= WAIT1;
                WAIT1: begin
                    if (tmr_zero) begin
                        if (v2_q) begin
                            bx_q      <= x2_q;
                            by_q      <= y2_q;
                            bh_q      <= h2_q;
                            go_draw_q <= 1'b1;
                            state_q   <= ISSUE2;
                        end else begin
                            state_q <= FIN;
                        end
                    end
                end
                ISSUE2: state_q <= WAIT2;
                WAIT2: begin
                    if (tmr_zero)
                        state_q <= FIN;
                end
                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign brickx      = bx_q;
    assign bricky      = by_q;
    assign brickhealth = bh_q;
    assign go_draw     = go_draw_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_brick_redraw_seq.sv
// Self-checking bench for brick_redraw_seq: directed and random
// operations compared against a draw-list model of the sequencer.
module tb_brick_redraw_seq;

    localparam int CW    = 10;
    localparam int HW    = 2;
    localparam int DC    = 40;
    localparam int LIMIT = 300;

    typedef struct {
        int k;
        int x;
        int y;
        int h;
    } draw_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          go = 1'b0;
    logic          collided_1 = 1'b0;
    logic [CW-1:0] col_x1 = '0;
    logic [CW-1:0] col_y1 = '0;
    logic [HW-1:0] col_health1 = '0;
    logic          collided_2 = 1'b0;
    logic [CW-1:0] col_x2 = '0;
    logic [CW-1:0] col_y2 = '0;
    logic [HW-1:0] col_health2 = '0;
    logic [CW-1:0] brickx;
    logic [CW-1:0] bricky;
    logic [HW-1:0] brickhealth;
    logic          go_draw;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int last_x = 0;
    int last_y = 0;
    int last_h = 0;

    brick_redraw_seq #(
        .COORD_W     (CW),
        .HEALTH_W    (HW),
        .DRAW_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .go          (go),
        .collided_1  (collided_1),
        .col_x1      (col_x1),
        .col_y1      (col_y1),
        .col_health1 (col_health1),
        .collided_2  (collided_2),
        .col_x2      (col_x2),
        .col_y2      (col_y2),
        .col_health2 (col_health2),
        .brickx      (brickx),
        .bricky      (bricky),
        .brickhealth (brickhealth),
        .go_draw     (go_draw),
        .busy        (busy),
        .done        (done)
    );

    always #10 clk = ~clk;

    task automatic scramble();
        collided_1  = 1'($urandom);
        collided_2  = 1'($urandom);
        col_x1      = CW'($urandom);
        col_y1      = CW'($urandom);
        col_health1 = HW'($urandom);
        col_x2      = CW'($urandom);
        col_y2      = CW'($urandom);
        col_health2 = HW'($urandom);
    endtask

    // Model: list of bricks to draw, draw i at cycle 2+(DC+1)*i,
    // done at 3+(DC+1)*n, outputs always equal the last drawn brick.
    task automatic run_op(input bit v1, input int x1, input int y1,
                          input int h1, input bit v2, input int x2,
                          input int y2, input int h2, input bit rego,
                          input string name);
        draw_t expq[$];
        draw_t obsq[$];
        draw_t d;
        int done_k = -1;
        int busy_n = 0;
        int hold_bad = 0;
        int exp_done;
        bit dedup = 1'b0;
`ifdef BRICK_REDRAW_DEDUP_EN
        dedup = 1'b1;
`endif
        if (v1 && !(dedup && v2 && x1 == x2 && y1 == y2)) begin
            d = '{k: 2 + (DC + 1) * expq.size(), x: x1, y: y1, h: h1};
            expq.push_back(d);
        end
        if (v2) begin
            d = '{k: 2 + (DC + 1) * expq.size(), x: x2, y: y2, h: h2};
            expq.push_back(d);
        end
        exp_done = 3 + (DC + 1) * expq.size();

        @(negedge clk);
        go = 1'b1;
        collided_1 = v1;
        col_x1 = CW'(x1);
        col_y1 = CW'(y1);
        col_health1 = HW'(h1);
        collided_2 = v2;
        col_x2 = CW'(x2);
        col_y2 = CW'(y2);
        col_health2 = HW'(h2);
        for (int k = 1; k <= LIMIT && done_k < 0; k++) begin
            @(negedge clk);
            if (go_draw) begin
                d = '{k: k, x: int'(brickx), y: int'(bricky),
                      h: int'(brickhealth)};
                obsq.push_back(d);
                last_x = int'(brickx);
                last_y = int'(bricky);
                last_h = int'(brickhealth);
            end
            if (obsq.size() < expq.size() && obsq.size() > 0 &&
                k > expq[obsq.size() - 1].k) begin
                last_x = expq[obsq.size() - 1].x;
                last_y = expq[obsq.size() - 1].y;
                last_h = expq[obsq.size() - 1].h;
            end
            if (int'(brickx) != last_x || int'(bricky) != last_y ||
                int'(brickhealth) != last_h)
                hold_bad++;
            if (busy)
                busy_n++;
            if (done)
                done_k = k;
            if (k == 1) begin
                go = 1'b0;
                scramble();
            end
            if (rego && k == 10) begin
                go = 1'b1;
                scramble();
            end
            if (rego && k == 11)
                go = 1'b0;
        end
        if (expq.size() > 0) begin
            last_x = expq[expq.size() - 1].x;
            last_y = expq[expq.size() - 1].y;
            last_h = expq[expq.size() - 1].h;
        end

        checks++;
        if (done_k !== exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d",
                     name, done_k, exp_done);
        end
        checks++;
        if (obsq.size() !== expq.size()) begin
            errors++;
            $display("FAIL %s draw_count: got %0d expected %0d",
                     name, obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            checks++;
            if (obsq[i] !== expq[i]) begin
                errors++;
                $display("FAIL %s draw%0d: got k=%0d (%0d,%0d,%0d) expected k=%0d (%0d,%0d,%0d)",
                         name, i, obsq[i].k, obsq[i].x, obsq[i].y, obsq[i].h,
                         expq[i].k, expq[i].x, expq[i].y, expq[i].h);
            end
        end
        checks++;
        if (busy_n !== exp_done - 1) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d",
                     name, busy_n, exp_done - 1);
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL %s hold: got %0d unstable cycles expected 0",
                     name, hold_bad);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, go_draw} !== 3'b000) begin
            errors++;
            $display("FAIL %s after_done: got done/busy/go_draw=%b expected 000",
                     name, {done, busy, go_draw});
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({brickx, bricky, brickhealth, go_draw, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state: got x=%0d y=%0d h=%0d gd=%b b=%b d=%b expected all 0",
                     brickx, bricky, brickhealth, go_draw, busy, done);
        end
        resetn = 1'b1;
        last_x = 0;
        last_y = 0;
        last_h = 0;
    endtask

    task automatic test_directed();
        run_op(0, 5, 6, 1, 0, 7, 8, 2, 0, "none");
        run_op(1, 24, 10, 1, 0, 0, 0, 0, 0, "rec1");
        run_op(1, 8, 4, 0, 1, 40, 16, 2, 0, "both");
        run_op(0, 0, 0, 0, 1, 100, 200, 3, 0, "rec2");
        run_op(1, 16, 8, 2, 1, 16, 8, 1, 0, "same_xy");
    endtask

    task automatic test_rego();
        run_op(1, 300, 301, 3, 1, 302, 303, 0, 1, "rego");
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(negedge clk);
        go = 1'b1;
        collided_1 = 1'b1;
        col_x1 = 10'd11;
        col_y1 = 10'd12;
        col_health1 = 2'd1;
        collided_2 = 1'b1;
        col_x2 = 10'd13;
        col_y2 = 10'd14;
        col_health2 = 2'd2;
        @(negedge clk);
        go = 1'b0;
        repeat (59) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({brickx, bricky, brickhealth, go_draw, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got x=%0d y=%0d h=%0d gd=%b b=%b d=%b expected all 0",
                     brickx, bricky, brickhealth, go_draw, busy, done);
        end
        resetn = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (go_draw || done || busy)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_abort: got %0d active cycles expected 0", bad);
        end
        last_x = 0;
        last_y = 0;
        last_h = 0;
        run_op(1, 50, 60, 2, 1, 70, 80, 3, 0, "post_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int x1 = int'($urandom_range(0, 1023));
            int y1 = int'($urandom_range(0, 1023));
            int x2 = int'($urandom_range(0, 1023));
            int y2 = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 0) begin
                x2 = x1;
                y2 = y1;
            end
            run_op(1'($urandom), x1, y1, int'($urandom_range(0, 3)),
                   1'($urandom), x2, y2, int'($urandom_range(0, 3)),
                   1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rego();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
